// File: rtl/writeback_if.sv
// Bundle between the execute/LSU/decode side and the writeback stage.
// Handshake: an LSU result transfers on a clock edge where lsu_valid && lsu_ready; the ALU side has no ready and is always taken.
interface writeback_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
);
  localparam int PEND_W = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic [1:0]            lsu_size;
  logic                  lsu_uns;

  logic [ADDR_WIDTH-1:0] chk_rs1;
  logic [ADDR_WIDTH-1:0] chk_rs2;
  logic [ADDR_WIDTH-1:0] chk_rd;
  logic                  hazard;

  logic                  wb_wen;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [PEND_W-1:0]     pending;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data, lsu_size, lsu_uns,
    output chk_rs1, chk_rs2, chk_rd,
    input  lsu_ready, hazard, wb_wen, wb_rd, wb_data, pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data, lsu_size, lsu_uns,
    input  chk_rs1, chk_rs2, chk_rd,
    output lsu_ready, hazard, wb_wen, wb_rd, wb_data, pending
  );
endinterface

// File: rtl/writeback_stage.sv
// Merges ALU results and extended LSU loads onto the single register-file write port,
// parking loads in a small FIFO while the ALU owns the port, and flags pending-load hazards to decode.
module writeback_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  writeback_if.slave  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PEND_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_ALU    = 2'd1,
    SEL_FIFO   = 2'd2,
    SEL_BYPASS = 2'd3
  } sel_e;

  // Registered state
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PEND_W-1:0]     pending_q, pending_d;
  logic                  in_reset_q, in_reset_d;
  logic                  wb_wen_q, wb_wen_d;
  logic [ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [ADDR_WIDTH-1:0] mem_rd_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];

  // Combinational
  sel_e                  sel;
  logic                  lsu_ready;
  logic                  lsu_accept;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] lsu_ext;
  logic                  hazard;
  logic [PTR_W-1:0]      slot_off;
  logic                  slot_valid;

  function automatic logic [DATA_WIDTH-1:0] extend_load(
    input logic [DATA_WIDTH-1:0] d,
    input logic [1:0]            size,
    input logic                  uns
  );
    logic [DATA_WIDTH-1:0] r;
    case (size)
      2'd0:    r = {{(DATA_WIDTH-8){~uns & d[7]}},   d[7:0]};
      2'd1:    r = {{(DATA_WIDTH-16){~uns & d[15]}}, d[15:0]};
      2'd2:    r = {{(DATA_WIDTH-32){~uns & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Index 0 is never a real dependency, so it can never raise a hazard.
  function automatic logic chk_hit(input logic [ADDR_WIDTH-1:0] rd);
    return (rd != '0) &&
           ((rd == bus.chk_rs1) || (rd == bus.chk_rs2) || (rd == bus.chk_rd));
  endfunction

  // Ready is a function of flops only so the LSU never sees a path from alu_valid.
  always_comb begin
    lsu_ready  = !in_reset_q && (pending_q < PEND_W'(DEPTH));
    lsu_accept = bus.lsu_valid && lsu_ready;
    fifo_empty = (pending_q == '0);
    lsu_ext    = extend_load(bus.lsu_data, bus.lsu_size, bus.lsu_uns);
  end

  // Arbitration: ALU first, then oldest parked load, then a load straight through.
  always_comb begin
    sel        = SEL_NONE;
    push       = 1'b0;
    pop        = 1'b0;
    in_reset_d = 1'b0;
    wb_wen_d   = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;

    if (bus.alu_valid) begin
      sel = SEL_ALU;
    end else if (!fifo_empty) begin
      sel = SEL_FIFO;
    end else if (lsu_accept) begin
      sel = SEL_BYPASS;
    end

    case (sel)
      SEL_ALU: begin
        wb_wen_d  = (bus.alu_rd != '0);
        wb_rd_d   = bus.alu_rd;
        wb_data_d = bus.alu_data;
        push      = lsu_accept;
      end
      SEL_FIFO: begin
        wb_wen_d  = (mem_rd_q[rd_ptr_q] != '0);
        wb_rd_d   = mem_rd_q[rd_ptr_q];
        wb_data_d = mem_data_q[rd_ptr_q];
        pop       = 1'b1;
        push      = lsu_accept;
      end
      SEL_BYPASS: begin
        wb_wen_d  = (bus.lsu_rd != '0);
        wb_rd_d   = bus.lsu_rd;
        wb_data_d = lsu_ext;
      end
      default: begin
        wb_wen_d = 1'b0;
      end
    endcase

    if (push) begin
      mem_rd_d[wr_ptr_q]   = bus.lsu_rd;
      mem_data_d[wr_ptr_q] = lsu_ext;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    pending_d = pending_q + PEND_W'(push) - PEND_W'(pop);
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    hazard     = lsu_accept && chk_hit(bus.lsu_rd);
    slot_off   = '0;
    slot_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off   = PTR_W'(i) - rd_ptr_q;
      slot_valid = ({1'b0, slot_off} < pending_q);
      if (slot_valid && chk_hit(mem_rd_q[i])) begin
        hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pending_q  <= '0;
      in_reset_q <= 1'b1;
      wb_wen_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pending_q  <= pending_d;
      in_reset_q <= in_reset_d;
      wb_wen_q   <= wb_wen_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

  assign bus.lsu_ready = lsu_ready;
  assign bus.hazard    = hazard;
  assign bus.wb_wen    = wb_wen_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: register-file writes are checked against an expected queue,
// occupancy/ready/hazard against directed expectations.
module tb_writeback_stage;
  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic mon_en;
  int   total;
  int   bad;

  logic [AW+DW-1:0] exp_q[$];

  writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  writeback_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run did not finish, got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [1:0] s, input logic u);
    int n;
    logic [63:0] mask;
    logic signed [63:0] t;
    if (s == 2'd3) return d;
    n    = 8 << s;
    mask = (64'd1 << n) - 64'd1;
    t    = $signed(d << (64 - n));
    return u ? (d & mask) : 64'(t >>> (64 - n));
  endfunction

  // Scoreboard: every enabled write must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en && bus.wb_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_write", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("sb_rd", 64'(bus.wb_rd), 64'(e[AW+DW-1:DW]));
        chk("sb_data", bus.wb_data, e[DW-1:0]);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                           input logic [1:0] s, input logic u);
    bus.lsu_valid = v;
    bus.lsu_rd    = rd;
    bus.lsu_data  = d;
    bus.lsu_size  = s;
    bus.lsu_uns   = u;
  endtask

  task automatic set_chk(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    bus.chk_rs1 = a;
    bus.chk_rs2 = b;
    bus.chk_rd  = c;
  endtask

  task automatic push_exp(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    if (rd != '0) exp_q.push_back({rd, d});
  endtask

  // Directed sequence
  logic [63:0] ext_d   [6];
  logic [1:0]  ext_s   [6];
  logic        ext_u   [6];
  logic [63:0] ext_e   [6];
  logic [63:0] rd_data;
  logic [1:0]  rs;
  logic        ru;
  logic [AW-1:0] rrd;
  logic [AW-1:0] lsu_idx;
  logic        acc;

  initial begin
    total  = 0;
    bad    = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    drive_alu(1'b1, 5'd5, 64'h77);
    drive_lsu(1'b0, '0, '0, 2'd0, 1'b0);
    set_chk('0, '0, '0);

    // Reset
    tick();
    tick();
    chk("rst_wen", 64'(bus.wb_wen), 64'd0);
    chk("rst_pending", 64'(bus.pending), 64'd0);
    chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    chk("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    rst_n = 1'b1;
    drive_alu(1'b0, '0, '0);
    tick();
    chk("rel_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    chk("rel_wen", 64'(bus.wb_wen), 64'd0);
    mon_en = 1'b1;

    // ALU only
    drive_alu(1'b1, 5'd5, 64'h1234);
    push_exp(5'd5, 64'h1234);
    tick();
    chk("alu_wen", 64'(bus.wb_wen), 64'd1);
    chk("alu_rd", 64'(bus.wb_rd), 64'd5);
    chk("alu_data", bus.wb_data, 64'h1234);
    drive_alu(1'b1, 5'd0, 64'h55);
    tick();
    chk("alu_rd0_wen", 64'(bus.wb_wen), 64'd0);
    drive_alu(1'b1, 5'd6, 64'hABCD);
    push_exp(5'd6, 64'hABCD);
    tick();
    drive_alu(1'b0, '0, '0);
    tick();
    chk("idle_wen", 64'(bus.wb_wen), 64'd0);
    chk("hold_rd", 64'(bus.wb_rd), 64'd6);
    chk("hold_data", bus.wb_data, 64'hABCD);

    // Extension through the bypass path
    ext_d[0] = 64'h80;               ext_s[0] = 2'd0; ext_u[0] = 1'b0; ext_e[0] = 64'hFFFF_FFFF_FFFF_FF80;
    ext_d[1] = 64'h80;               ext_s[1] = 2'd0; ext_u[1] = 1'b1; ext_e[1] = 64'h80;
    ext_d[2] = 64'h8000_0000;        ext_s[2] = 2'd2; ext_u[2] = 1'b0; ext_e[2] = 64'hFFFF_FFFF_8000_0000;
    ext_d[3] = 64'h1234_8000;        ext_s[3] = 2'd1; ext_u[3] = 1'b0; ext_e[3] = 64'hFFFF_FFFF_FFFF_8000;
    ext_d[4] = 64'hFFFF_FFFF_8000_0000; ext_s[4] = 2'd2; ext_u[4] = 1'b1; ext_e[4] = 64'h8000_0000;
    ext_d[5] = 64'h8123_4567_89AB_CDEF; ext_s[5] = 2'd3; ext_u[5] = 1'b0; ext_e[5] = 64'h8123_4567_89AB_CDEF;
    for (int k = 0; k < 6; k++) begin
      drive_lsu(1'b1, AW'(10 + k), ext_d[k], ext_s[k], ext_u[k]);
      chk("ext_ready", 64'(bus.lsu_ready), 64'd1);
      push_exp(AW'(10 + k), ext_e[k]);
      tick();
      chk("ext_data", bus.wb_data, ext_e[k]);
      chk("ext_pending", 64'(bus.pending), 64'd0);
    end
    for (int k = 0; k < 8; k++) begin
      rd_data = {$urandom, $urandom};
      rs      = 2'($urandom_range(0, 3));
      ru      = 1'($urandom_range(0, 1));
      rrd     = AW'($urandom_range(1, 31));
      drive_lsu(1'b1, rrd, rd_data, rs, ru);
      push_exp(rrd, ext_model(rd_data, rs, ru));
      tick();
    end
    drive_lsu(1'b0, '0, '0, 2'd0, 1'b0);
    tick();

    // Collision: ALU wins, load parked one cycle
    drive_alu(1'b1, 5'd3, 64'hA3);
    drive_lsu(1'b1, 5'd7, 64'hB7, 2'd3, 1'b0);
    push_exp(5'd3, 64'hA3);
    push_exp(5'd7, 64'hB7);
    tick();
    chk("col_rd1", 64'(bus.wb_rd), 64'd3);
    chk("col_pending1", 64'(bus.pending), 64'd1);
    drive_alu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0, 2'd0, 1'b0);
    set_chk(5'd7, '0, '0);
    #1;
    chk("col_hazard", 64'(bus.hazard), 64'd1);
    set_chk('0, '0, '0);
    tick();
    chk("col_rd2", 64'(bus.wb_rd), 64'd7);
    chk("col_wen2", 64'(bus.wb_wen), 64'd1);
    chk("col_pending2", 64'(bus.pending), 64'd0);

    // Hazard against a parked entry
    drive_alu(1'b1, 5'd2, 64'h22);
    drive_lsu(1'b1, 5'd9, 64'h99, 2'd3, 1'b0);
    push_exp(5'd2, 64'h22);
    push_exp(5'd9, 64'h99);
    set_chk(5'd4, 5'd4, 5'd4);
    #1;
    chk("haz_unrelated", 64'(bus.hazard), 64'd0);
    tick();
    drive_alu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0, 2'd0, 1'b0);
    set_chk('0, 5'd9, '0);
    #1;
    chk("haz_rs2", 64'(bus.hazard), 64'd1);
    set_chk('0, '0, 5'd9);
    #1;
    chk("haz_rd", 64'(bus.hazard), 64'd1);
    set_chk(5'd8, 5'd8, 5'd8);
    #1;
    chk("haz_none", 64'(bus.hazard), 64'd0);
    tick();
    set_chk('0, 5'd9, '0);
    #1;
    chk("haz_drained", 64'(bus.hazard), 64'd0);
    drive_lsu(1'b1, 5'd12, 64'hC, 2'd3, 1'b0);
    set_chk(5'd12, '0, '0);
    #1;
    chk("haz_bypass", 64'(bus.hazard), 64'd1);
    push_exp(5'd12, 64'hC);
    tick();
    drive_lsu(1'b0, '0, '0, 2'd0, 1'b0);

    // Parked entry with rd 0
    drive_alu(1'b1, 5'd2, 64'h24);
    drive_lsu(1'b1, 5'd0, 64'hDEAD, 2'd3, 1'b0);
    push_exp(5'd2, 64'h24);
    tick();
    drive_alu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0, 2'd0, 1'b0);
    chk("rd0_pending", 64'(bus.pending), 64'd1);
    set_chk('0, '0, '0);
    #1;
    chk("haz_rd0", 64'(bus.hazard), 64'd0);
    tick();
    chk("rd0_wen", 64'(bus.wb_wen), 64'd0);
    chk("rd0_pending_after", 64'(bus.pending), 64'd0);

    // Fill and drain
    for (int k = 0; k < 6; k++) push_exp(AW'(20 + k), 64'h100 + 64'(k));
    for (int k = 1; k <= 5; k++) push_exp(AW'(k), 64'h200 + 64'(k));
    lsu_idx = 5'd1;
    for (int k = 0; k < 6; k++) begin
      drive_alu(1'b1, AW'(20 + k), 64'h100 + 64'(k));
      drive_lsu(1'b1, lsu_idx, 64'h200 + 64'(lsu_idx), 2'd3, 1'b0);
      chk("fill_ready", 64'(bus.lsu_ready), (k < 4) ? 64'd1 : 64'd0);
      if (bus.lsu_ready) lsu_idx = lsu_idx + 5'd1;
      tick();
    end
    chk("fill_pending", 64'(bus.pending), 64'd4);
    drive_alu(1'b0, '0, '0);
    for (int c = 0; c < 20; c++) begin
      acc = bus.lsu_valid && bus.lsu_ready;
      tick();
      if (acc) drive_lsu(1'b0, '0, '0, 2'd0, 1'b0);
      if (bus.pending == '0 && exp_q.size() == 0) break;
    end
    chk("drain_pending", 64'(bus.pending), 64'd0);

    tick();
    tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
